dtmr_fault_monitor: RTL and testbench



---
 rtl/dtmr_mon_pkg.sv | 23 ++
 rtl/dtmr_mon_replica_track.sv | 64 ++++++
 rtl/dtmr_fault_monitor.sv | 92 +++++++++
 tb/tb_dtmr_fault_monitor.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/dtmr_mon_pkg.sv
// rtl/dtmr_mon_pkg.sv - shared types, constants and helpers for the DTMR fault monitor
package dtmr_mon_pkg;

    localparam int STATE_W  = 2;
    localparam int ERR_ID_W = 2;

    typedef enum logic [STATE_W-1:0] {
        NOMINAL  = 2'd0,
        DEGRADED = 2'd1,
        CRITICAL = 2'd2
    } mon_state_e;

    localparam logic [ERR_ID_W-1:0] ERR_NONE = 2'd3;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/dtmr_mon_replica_track.sv
// rtl/dtmr_mon_replica_track.sv - per-replica sticky/run/persist tracking, counter under DTMR_MON_COUNTERS_EN
module dtmr_mon_replica_track
    import dtmr_mon_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int PERSIST_N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    input  logic             clr,
    output logic             sticky,
    output logic             persist,
    output logic             persist_next,
    output logic [CNT_W-1:0] cnt
);

    localparam int RUN_W = $clog2(PERSIST_N + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PERSIST_N);

    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;

    always_comb begin
        run_next = '0;
        if (d) begin
            run_next = (run == RUN_MAX) ? run : run + 1'b1;
        end
    end

    // persist_next feeds the top-level FSM so state moves on the same edge persist rises
    assign persist_next = clr ? 1'b0 : (persist | (run_next == RUN_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky  <= 1'b0;
            persist <= 1'b0;
            run     <= '0;
        end else if (clr) begin
            sticky  <= 1'b0;
            persist <= 1'b0;
            run     <= '0;
        end else begin
            sticky  <= sticky | d;
            persist <= persist_next;
            run     <= run_next;
        end
    end

`ifdef DTMR_MON_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (d && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign cnt = '0;
`endif

endmodule

// File: rtl/dtmr_fault_monitor.sv
// rtl/dtmr_fault_monitor.sv - DTMR replica fault monitor top; counters built only with DTMR_MON_COUNTERS_EN
module dtmr_fault_monitor
    import dtmr_mon_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int PERSIST_N = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rep_0,
    input  logic                rep_1,
    input  logic                rep_2,
    input  logic                clr,
    output logic                voted,
    output logic                err_pulse,
    output logic [ERR_ID_W-1:0] err_id,
    output logic [2:0]          sticky,
    output logic [2:0]          persist,
    output logic [STATE_W-1:0]  state,
    output logic [CNT_W-1:0]    cnt_0,
    output logic [CNT_W-1:0]    cnt_1,
    output logic [CNT_W-1:0]    cnt_2
);

    logic                m;
    logic [2:0]          d;
    logic [2:0]          persist_next;
    logic [ERR_ID_W-1:0] err_id_next;
    mon_state_e          state_q;
    mon_state_e          state_next;

    assign m = maj3(rep_0, rep_1, rep_2);
    assign d = {rep_2 ^ m, rep_1 ^ m, rep_0 ^ m};

    always_comb begin
        err_id_next = ERR_NONE;
        if (d[0])      err_id_next = 2'd0;
        else if (d[1]) err_id_next = 2'd1;
        else if (d[2]) err_id_next = 2'd2;
    end

    dtmr_mon_replica_track #(.CNT_W(CNT_W), .PERSIST_N(PERSIST_N)) u_track_0 (
        .clk(clk), .rst_n(rst_n), .d(d[0]), .clr(clr),
        .sticky(sticky[0]), .persist(persist[0]), .persist_next(persist_next[0]), .cnt(cnt_0)
    );

    dtmr_mon_replica_track #(.CNT_W(CNT_W), .PERSIST_N(PERSIST_N)) u_track_1 (
        .clk(clk), .rst_n(rst_n), .d(d[1]), .clr(clr),
        .sticky(sticky[1]), .persist(persist[1]), .persist_next(persist_next[1]), .cnt(cnt_1)
    );

    dtmr_mon_replica_track #(.CNT_W(CNT_W), .PERSIST_N(PERSIST_N)) u_track_2 (
        .clk(clk), .rst_n(rst_n), .d(d[2]), .clr(clr),
        .sticky(sticky[2]), .persist(persist[2]), .persist_next(persist_next[2]), .cnt(cnt_2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voted     <= 1'b0;
            err_pulse <= 1'b0;
            err_id    <= ERR_NONE;
            state_q   <= NOMINAL;
        end else begin
            voted     <= m;
            err_pulse <= clr ? 1'b0 : |d;
            err_id    <= clr ? ERR_NONE : err_id_next;
            state_q   <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        if (clr) begin
            state_next = NOMINAL;
        end else begin
            case (state_q)
                NOMINAL: begin
                    if (popcount3(persist_next) >= 2'd2)      state_next = CRITICAL;
                    else if (popcount3(persist_next) == 2'd1) state_next = DEGRADED;
                end
                DEGRADED: begin
                    if (popcount3(persist_next) >= 2'd2) state_next = CRITICAL;
                end
                CRITICAL: state_next = CRITICAL;
                default:  state_next = NOMINAL;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_dtmr_fault_monitor.sv
// tb/tb_dtmr_fault_monitor.sv - directed self-checking bench for dtmr_fault_monitor
module tb_dtmr_fault_monitor;

`ifdef DTMR_MON_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rep_0 = 1'b1, rep_1 = 1'b1, rep_2 = 1'b1;
    logic clr = 1'b0;

    logic       voted, err_pulse;
    logic [1:0] err_id, state;
    logic [2:0] sticky, persist;
    logic [7:0] cnt_0, cnt_1, cnt_2;

    logic       s_voted, s_err_pulse;
    logic [1:0] s_err_id, s_state;
    logic [2:0] s_sticky, s_persist;
    logic [1:0] s_cnt_0, s_cnt_1, s_cnt_2;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dtmr_fault_monitor #(.CNT_W(8), .PERSIST_N(4)) dut (
        .clk(clk), .rst_n(rst_n), .rep_0(rep_0), .rep_1(rep_1), .rep_2(rep_2), .clr(clr),
        .voted(voted), .err_pulse(err_pulse), .err_id(err_id), .sticky(sticky),
        .persist(persist), .state(state), .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2)
    );

    dtmr_fault_monitor #(.CNT_W(2), .PERSIST_N(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .rep_0(rep_0), .rep_1(rep_1), .rep_2(rep_2), .clr(clr),
        .voted(s_voted), .err_pulse(s_err_pulse), .err_id(s_err_id), .sticky(s_sticky),
        .persist(s_persist), .state(s_state), .cnt_0(s_cnt_0), .cnt_1(s_cnt_1), .cnt_2(s_cnt_2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] cexp(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        if (!CNT_EN) return 32'd0;
        return (v > mx) ? mx : v;
    endfunction

    task automatic step(input logic a, input logic b, input logic c, input logic cl);
        @(negedge clk);
        rep_0 = a; rep_1 = b; rep_2 = c; clr = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_voted", voted, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_id", err_id, 3);
        check("rst_sticky", sticky, 0);
        check("rst_persist", persist, 0);
        check("rst_state", state, 0);
        check("rst_cnt", {cnt_0, cnt_1, cnt_2}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rel_voted_held", voted, 0);

        step(1, 1, 1, 0);
        check("first_voted", voted, 1);
        check("first_err_id", err_id, 3);
        check("first_err_pulse", err_pulse, 0);

        // single-cycle disagreement on replica 1
        step(1, 0, 1, 0);
        check("r1_pulse", err_pulse, 1);
        check("r1_err_id", err_id, 1);
        check("r1_sticky", sticky, 3'b010);
        check("r1_cnt1", cnt_1, cexp(1, 8));
        check("r1_persist", persist, 0);
        check("r1_state", state, 0);
        step(1, 1, 1, 0);
        check("r1_pulse_end", err_pulse, 0);
        check("r1_err_id_end", err_id, 3);
        check("r1_sticky_held", sticky, 3'b010);

        // replica 2 stuck for PERSIST_N cycles
        step(1, 1, 1, 1);
        check("clr_sticky", sticky, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            if (i == 2) check("stuck_persist_early", persist, 0);
        end
        check("stuck_persist", persist, 3'b100);
        check("stuck_state", state, 1);
        check("stuck_cnt2", cnt_2, cexp(4, 8));
        check("stuck_err_id", err_id, 2);
        check("stuck_voted", voted, 1);

        // interrupted run never reaches persist
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        check("run_persist", persist, 0);
        check("run_cnt2", cnt_2, cexp(6, 8));
        check("run_state", state, 0);
        check("run_voted", voted, 0);
        check("run_pulse_b2b", err_pulse, 1);

        // saturation then escalation to critical
        step(1, 1, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0);
        check("sat_cnt0_w2", s_cnt_0, cexp(6, 2));
        check("sat_cnt0_w8", cnt_0, cexp(6, 8));
        check("sat_persist", persist, 3'b001);
        check("sat_state", state, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0);
        check("crit_persist", persist, 3'b011);
        check("crit_state", state, 2);
        check("crit_state_w2", s_state, 2);
        check("crit_cnt1_w2", s_cnt_1, cexp(4, 2));
        step(1, 1, 1, 0);
        check("crit_absorb", state, 2);

        // clear wins over a disagreement in the same cycle
        step(1, 0, 1, 1);
        check("clr_sticky2", sticky, 0);
        check("clr_persist", persist, 0);
        check("clr_cnt1", cnt_1, 0);
        check("clr_cnt0", cnt_0, 0);
        check("clr_pulse", err_pulse, 0);
        check("clr_err_id", err_id, 3);
        check("clr_state", state, 0);
        check("clr_voted", voted, 1);

        // asynchronous reset mid-operation
        step(1, 1, 0, 0);
        check("pre_rst_sticky", sticky, 3'b100);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sticky", sticky, 0);
        check("arst_err_id", err_id, 3);
        check("arst_voted", voted, 0);
        check("arst_cnt2", cnt_2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        check("post_rst_pulse", err_pulse, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
